// File: rtl/vx_operands_queue_pkg.sv
// Operand record layout shared by the operand queue and its channel FIFOs.
// Purely declarative: no latency, no flow control.
// Record width is taken from data_t so a layout change resizes the queue.
package vx_operands_queue_pkg;

  typedef struct packed {
    logic [7:0]  uuid;
    logic [1:0]  wis;
    logic [3:0]  tmask;
    logic [15:0] pc;
    logic [1:0]  ex_type;
    logic [3:0]  op_type;
    logic [3:0]  rd;
    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic [7:0]  rs3_data;
  } data_t;

  localparam int OPQ_DATAW = $bits(data_t);

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/vx_operands_chfifo.sv
// Per-channel operand FIFO: register storage, pointers, count and flush.
// Latency: a pushed record is at head_data from the next cycle.
// Backpressure: the caller gates push/pop; flush empties the channel in one edge.
module vx_operands_chfifo #(
  parameter int DEPTH = 4,
  parameter int DATAW = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [DATAW-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Flush resynchronises the read pointer to the write pointer rather than
  // zeroing both, so stale storage is never observed as valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (count < CNT_W'(DEPTH)) && !flush);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (count != '0) && !flush);
  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count <= CNT_W'(DEPTH));

endmodule

// File: rtl/vx_operands_queue.sv
// Multi-channel operand buffer: per-channel FIFOs drained by a round-robin arbiter.
// Latency: a record pushed at edge t is presented at out_data from cycle t+1.
// Backpressure: a stalled grant is locked until it fires or its channel is flushed.
module vx_operands_queue
  import vx_operands_queue_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int DATAW  = OPQ_DATAW,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*DATAW-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH-1:0]       flush,
  output logic                    out_valid,
  output logic [DATAW-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] occupancy
);

  logic [DATAW-1:0] head_data [NUM_CH];
  logic [CNT_W-1:0] count     [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] req;

  logic [CH_W-1:0] rr_ptr;
  logic            lock_vld;
  logic [CH_W-1:0] lock_ch;
  logic            lock_hold;
  logic            pick_vld;
  logic [CH_W-1:0] pick_ch;
  logic            grant_vld;
  logic [CH_W-1:0] grant_ch;
  logic            fire;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // A full channel stays not-ready even while being popped: no pass-through.
    assign in_ready[c] = (count[c] < CNT_W'(DEPTH)) && !flush[c];
    assign push[c]     = in_valid[c] && in_ready[c];
    assign pop[c]      = fire && (grant_ch == CH_W'(c));
    assign req[c]      = (count[c] != '0) && !flush[c];
    assign occupancy[c*CNT_W +: CNT_W] = count[c];

    vx_operands_chfifo #(
      .DEPTH (DEPTH),
      .DATAW (DATAW),
      .CNT_W (CNT_W)
    ) u_chfifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[c]),
      .push_data (in_data[c*DATAW +: DATAW]),
      .pop       (pop[c]),
      .flush     (flush[c]),
      .head_data (head_data[c]),
      .count     (count[c])
    );
  end

  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_ch  = CH_W'(idx);
      end
    end
  end

  // The locked channel cannot drain except by its own pop or a flush,
  // so holding it only needs the flush check.
  assign lock_hold = lock_vld && !flush[lock_ch];
  assign grant_vld = lock_hold || pick_vld;
  assign grant_ch  = lock_hold ? lock_ch : pick_ch;
  assign fire      = grant_vld && out_ready;

  assign out_valid = grant_vld;
  assign out_ch    = grant_ch;
  assign out_data  = head_data[grant_ch];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_ch  <= '0;
    end else begin
      if (fire) begin
        rr_ptr   <= CH_W'(wrap_inc(int'(grant_ch), NUM_CH));
        lock_vld <= 1'b0;
      end else if (grant_vld) begin
        lock_vld <= 1'b1;
        lock_ch  <= grant_ch;
      end else begin
        lock_vld <= 1'b0;
      end
    end
  end

  a_stable_grant: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready && !flush[out_ch]) |=>
      (flush[$past(out_ch)] || (out_ch == $past(out_ch) && out_data == $past(out_data))));

endmodule
